// File: rtl/uart_rx_core.sv
// UART receive core: 3-sample majority voter, frame FSM, deserializer and
// parity/stop/break checking, clocked by the oversampling clock.
module uart_rx_core #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      parity_en,
  input  logic                      parity_type,
  input  logic                      two_stop,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      parity_error,
  output logic                      stop_error,
  output logic                      break_detect,
  output logic                      busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StOutput
  } state_e;

  state_e                    state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt, presc_l;
  logic                      par_en_l, par_type_l, two_stop_l;
  logic [CntW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      samp0, samp1, par_bit, stop1_bit, stop2_bit;

  logic [PRESCALE_WIDTH-1:0] half, edge_nxt;
  logic at_hm1, at_h, at_mid, at_last, at_pre;
  logic maj, exp_par, par_err, stp_err, is_break;

  always_comb begin
    half     = presc_l >> 1;
    at_hm1   = (edge_cnt == half - PRESCALE_WIDTH'(1));
    at_h     = (edge_cnt == half);
    at_mid   = (edge_cnt == half + PRESCALE_WIDTH'(1));
    at_last  = (edge_cnt == presc_l - PRESCALE_WIDTH'(1));
    at_pre   = (edge_cnt == presc_l - PRESCALE_WIDTH'(2));
    edge_nxt = at_last ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
    // Two stored samples plus the live line form the vote at edge h+1.
    maj      = (samp0 & samp1) | (samp0 & rx_in) | (samp1 & rx_in);
    exp_par  = (^shreg) ^ par_type_l;
    par_err  = par_en_l & (par_bit != exp_par);
    stp_err  = ~stop1_bit | (two_stop_l & ~stop2_bit);
    is_break = (shreg == '0) & (~par_en_l | ~par_bit) & ~stop1_bit;
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= StIdle;
      edge_cnt     <= '0;
      presc_l      <= '0;
      par_en_l     <= 1'b0;
      par_type_l   <= 1'b0;
      two_stop_l   <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      samp0        <= 1'b0;
      samp1        <= 1'b0;
      par_bit      <= 1'b0;
      stop1_bit    <= 1'b0;
      stop2_bit    <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      break_detect <= 1'b0;
      if (at_hm1) samp0 <= rx_in;
      if (at_h)   samp1 <= rx_in;
      // Configuration is frozen for the whole frame from its first START cycle.
      if ((state == StIdle || state == StOutput) && !rx_in) begin
        presc_l    <= prescale;
        par_en_l   <= parity_en;
        par_type_l <= parity_type;
        two_stop_l <= two_stop;
      end
      unique case (state)
        StIdle: begin
          edge_cnt <= '0;
          if (!rx_in) state <= StStart;
        end
        StStart: begin
          edge_cnt <= edge_nxt;
          if (at_mid && maj) begin
            state    <= StIdle;
            edge_cnt <= '0;
          end else if (at_last) begin
            state   <= StData;
            bit_cnt <= '0;
          end
        end
        StData: begin
          edge_cnt <= edge_nxt;
          if (at_mid) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
          if (at_last) begin
            if (bit_cnt == LastBit) state <= par_en_l ? StParity : StStop1;
            else                    bit_cnt <= bit_cnt + 1'b1;
          end
        end
        StParity: begin
          edge_cnt <= edge_nxt;
          if (at_mid)  par_bit <= maj;
          if (at_last) state <= StStop1;
        end
        StStop1: begin
          edge_cnt <= edge_nxt;
          if (at_mid) stop1_bit <= maj;
          if (two_stop_l && at_last) begin
            state <= StStop2;
          end else if (!two_stop_l && at_pre) begin
            state    <= StOutput;
            edge_cnt <= '0;
          end
        end
        StStop2: begin
          edge_cnt <= edge_nxt;
          if (at_mid) stop2_bit <= maj;
          if (at_pre) begin
            state    <= StOutput;
            edge_cnt <= '0;
          end
        end
        StOutput: begin
          edge_cnt     <= '0;
          parity_error <= par_err;
          stop_error   <= stp_err;
          if (is_break) begin
            break_detect <= 1'b1;
          end else if (!par_err && !stp_err) begin
            data_valid <= 1'b1;
            data_out   <= shreg;
          end
          state <= rx_in ? StIdle : StStart;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core: integrated oversampling majority voter, frame FSM, edge/bit counters, deserializer and parity/stop/break checking in one block. Supports configurable data width, even/odd/no parity and one or two stop bits. Sits between the synchronised serial input pin and the byte-level consumer (FIFO or register interface), driven by the system oversampling clock.

## Interface

- DATA_WIDTH, 8, data bits per frame, legal 5..9
- PRESCALE_WIDTH, 6, width of prescale input
- clock  input  1  oversampling clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rx_in  input  1  serial line, already synchronised, idle high
- prescale  input  PRESCALE_WIDTH  clocks per bit; even, 8..62
- parity_en  input  1  1 = parity bit present
- parity_type  input  1  0 = even, 1 = odd
- two_stop  input  1  1 = two stop bits
- data_out  output  DATA_WIDTH  last good word, LSB first on line
- data_valid  output  1  one-clock pulse, new data_out
- parity_error  output  1  result of last completed frame
- stop_error  output  1  result of last completed frame (framing)
- break_detect  output  1  one-clock pulse, break frame received
- busy  output  1  FSM not in IDLE

## Operation

- States: IDLE, START, DATA, PARITY, STOP1, STOP2, OUTPUT.
- edge_cnt counts 0..prescale-1 per bit period, cleared on every state entry from IDLE/OUTPUT and on wrap. h = prescale>>1.
- Samples of rx_in taken at edge_cnt h-1, h, h+1; bit = majority of the three, valid at edge h+1 (two stored + live).
- Config (prescale, parity_en, parity_type, two_stop) latched on IDLE->START and OUTPUT->START; mid-frame changes ignored.
- IDLE: rx_in==0 -> START.
- START: at h+1, bit==1 -> IDLE (glitch, no outputs change); at prescale-1 -> DATA, bit_cnt=0.
- DATA: at h+1 shift bit into shift register MSB, shifting right (LSB-first line order). At prescale-1: bit_cnt==DATA_WIDTH-1 -> PARITY if parity_en else STOP1; otherwise bit_cnt+1.
- PARITY: at h+1 capture parity bit; at prescale-1 -> STOP1.
- STOP1: at h+1 capture stop bit 1; two_stop: at prescale-1 -> STOP2; else at prescale-2 -> OUTPUT.
- STOP2: at h+1 capture stop bit 2; at prescale-2 -> OUTPUT.
- OUTPUT: exactly one clock. rx_in==0 -> START, else IDLE.
- Expected parity = XOR(data) XOR parity_type; parity_error = parity_en and received != expected; forced 0 when parity_en=0.
- stop_error = any captured stop bit == 0.
- Break: all data bits 0, parity bit 0 (if enabled), stop bit 1 == 0 -> break_detect pulse, data_valid suppressed, stop_error=1.

## Timing

- Reset: state IDLE, counters 0, data_out 0, data_valid 0, parity_error 0, stop_error 0, break_detect 0, busy 0.
- Reset mid-frame: immediate abort to IDLE; no pulses; error flags cleared.
- All outputs registered. At the clock edge leaving OUTPUT: parity_error/stop_error updated (held until next completed frame); data_valid=1 and data_out loaded only if no error; break_detect per rule. Pulses last one clock.
- Frame length exactly (1+DATA_WIDTH+parity_en+1+two_stop) x prescale clocks from first START cycle to end of OUTPUT; OUTPUT replaces last stop-bit cycle so back-to-back frames keep alignment.
- data_valid rises one clock after last stop-bit period ends.
- busy is registered state != IDLE; glitched start gives busy high h+2 clocks.

## Test plan

- DATA_WIDTH 8, prescale 8, 8N1, byte 0xA5 -> data_valid one pulse, data_out 0xA5, errors 0, 80 clocks start-to-pulse.
- 8E1, byte 0x03 with parity bit 1 -> parity_error=1, data_valid 0, data_out unchanged; next frame 0x03 with parity 0 -> parity_error clears, data_valid pulse.
- rx_in low 3 clocks then high, prescale 16 -> return to IDLE at edge 9, no pulses, busy falls.
- DATA_WIDTH 7, two_stop=1, second stop sampled 0 -> stop_error=1, no data_valid.
- Three back-to-back 8N1 frames 0x00,0xFF,0x5A, no idle gap -> three data_valid pulses exactly 10 x prescale apart, correct data.
- All-zero line for full 8E1 frame -> break_detect pulse, stop_error=1, data_valid 0; reset asserted mid-DATA of next frame -> all outputs 0, IDLE.
